// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard sequencer.
// Produces the decoder stall plus the PC, IF/ID and ID/EX enables and flushes.
// It handles load-use stalls, multi-cycle taken-branch flushes and dmem freezes.
// Optional build macro HAZARD_STATS_EN adds saturating event counters
// (stat_stall, stat_flush, stat_freeze).
module hazard_ctrl #(
   parameter int BR_FLUSH_CYCLES = 1,
   parameter int XLEN_REG        = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [6:0]          id_opcode,
   input  logic [XLEN_REG-1:0] id_rs1,
   input  logic [XLEN_REG-1:0] id_rs2,
   input  logic [XLEN_REG-1:0] id_rd,
   input  logic                ex_branch_taken,
   input  logic                dmem_busy,
   output logic                stall,
   output logic                pc_write,
   output logic                ifid_write,
   output logic                idex_write,
   output logic                ifid_flush,
   output logic                idex_flush
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]         stat_stall,
   output logic [15:0]         stat_flush,
   output logic [15:0]         stat_freeze
`endif
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t              state_reg, state_next;
   logic [2:0]          flush_cnt_reg, flush_cnt_next;
   logic [XLEN_REG-1:0] ex_rd_reg, ex_rd_next;
   logic                ex_load_reg, ex_load_next;

   logic uses_rs1, uses_rs2, load_use;
   logic ev_stall, ev_flush, ev_freeze;

   // Source-register usage by opcode class and the load-use match against EX
   always_comb begin
      uses_rs1 = (id_opcode == OP_LOAD) || (id_opcode == OP_STORE) || (id_opcode == OP_R) ||
                 (id_opcode == OP_BRANCH) || (id_opcode == OP_IMM);
      uses_rs2 = (id_opcode == OP_STORE) || (id_opcode == OP_R) || (id_opcode == OP_BRANCH);
      load_use = id_valid && ex_load_reg && (ex_rd_reg != '0) &&
                 ((uses_rs1 && (id_rs1 == ex_rd_reg)) || (uses_rs2 && (id_rs2 == ex_rd_reg)));
   end

   // Prioritised output decode and next-state: rst > freeze > flush > load-use > run
   always_comb begin
      stall          = 1'b0;
      pc_write       = 1'b1;
      ifid_write     = 1'b1;
      idex_write     = 1'b1;
      ifid_flush     = 1'b0;
      idex_flush     = 1'b0;
      state_next     = state_reg;
      flush_cnt_next = flush_cnt_reg;
      ex_rd_next     = ex_rd_reg;
      ex_load_next   = ex_load_reg;
      ev_stall       = 1'b0;
      ev_flush       = 1'b0;
      ev_freeze      = 1'b0;
      if (rst) begin
         stall          = 1'b1;
         pc_write       = 1'b0;
         ifid_write     = 1'b0;
         idex_write     = 1'b0;
         ifid_flush     = 1'b1;
         idex_flush     = 1'b1;
         state_next     = RUN;
         flush_cnt_next = '0;
         ex_rd_next     = '0;
         ex_load_next   = 1'b0;
      end else if (dmem_busy) begin
         // Whole pipeline holds; EX keeps its instruction so a pending branch reappears later
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_write = 1'b0;
         ev_freeze  = 1'b1;
      end else if (state_reg == FLUSH || ex_branch_taken) begin
         stall        = 1'b1;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         ex_rd_next   = '0;
         ex_load_next = 1'b0;
         ev_flush     = 1'b1;
         if (state_reg == RUN) begin
            if (BR_FLUSH_CYCLES > 1) begin
               state_next     = FLUSH;
               flush_cnt_next = 3'(BR_FLUSH_CYCLES - 1);
            end
         end else begin
            flush_cnt_next = flush_cnt_reg - 3'd1;
            if (flush_cnt_reg == 3'd1) begin
               state_next = RUN;
            end
         end
      end else if (load_use) begin
         // One bubble into EX; it clears ex_load so the stall lasts a single cycle
         stall        = 1'b1;
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         ex_rd_next   = '0;
         ex_load_next = 1'b0;
         ev_stall     = 1'b1;
      end else begin
         ex_rd_next   = id_rd;
         ex_load_next = id_valid && (id_opcode == OP_LOAD);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      ex_rd_reg     <= ex_rd_next;
      ex_load_reg   <= ex_load_next;
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stat_stall_reg, stat_flush_reg, stat_freeze_reg;

   // Saturating event counters, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_reg  <= '0;
         stat_flush_reg  <= '0;
         stat_freeze_reg <= '0;
      end else begin
         if (ev_stall && stat_stall_reg != 16'hFFFF)   stat_stall_reg  <= stat_stall_reg + 16'd1;
         if (ev_flush && stat_flush_reg != 16'hFFFF)   stat_flush_reg  <= stat_flush_reg + 16'd1;
         if (ev_freeze && stat_freeze_reg != 16'hFFFF) stat_freeze_reg <= stat_freeze_reg + 16'd1;
      end
   end

   assign stat_stall  = stat_stall_reg;
   assign stat_flush  = stat_flush_reg;
   assign stat_freeze = stat_freeze_reg;
`else
   // Event strobes only feed the optional counters
   logic unused_ev;
   assign unused_ev = ev_stall ^ ev_flush ^ ev_freeze;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl with BR_FLUSH_CYCLES=2.
// A rule-level model is checked on every cycle, and directed literal expectations pin it.
module tb_hazard_ctrl;

   localparam int BRC = 2;
   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011,
                          BR = 7'b1100011, IM = 7'b0010011, NOP = 7'b0000000;
   // packed {stall, pc_write, ifid_write, idex_write, ifid_flush, idex_flush}
   localparam logic [5:0] V_RUN = 6'b011100, V_STALL = 6'b100100, V_FLUSH = 6'b111111,
                          V_FRZ = 6'b000000, V_RST = 6'b100011;

   logic clk = 1'b0;
   logic rst, id_valid, ex_branch_taken, dmem_busy;
   logic [6:0] id_opcode;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic stall, pc_write, ifid_write, idex_write, ifid_flush, idex_flush;

   int n_checks = 0;
   int n_pass   = 0;

   hazard_ctrl #(.BR_FLUSH_CYCLES(BRC), .XLEN_REG(5)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
      .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
      .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] outs();
      return {stall, pc_write, ifid_write, idex_write, ifid_flush, idex_flush};
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   // ---- behavioural model: what EX holds and how many flush cycles remain ----
   int         m_flush_left = 0;
   logic [4:0] m_ex_rd      = 0;
   bit         m_ex_load    = 0;
   bit         started      = 0;

   function automatic bit reads_reg(input logic [6:0] op, input logic [4:0] s1,
                                    input logic [4:0] s2, input logic [4:0] r);
      bit r1, r2;
      r1 = (op inside {LD, ST, RR, BR, IM}) && s1 == r;
      r2 = (op inside {ST, RR, BR}) && s2 == r;
      return r1 || r2;
   endfunction

   // Compare and advance the model once per cycle, mid-cycle when inputs are stable
   always @(negedge clk) begin
      logic [5:0] exp;
      if (rst) started = 1;
      if (started) begin
         if (rst) begin
            exp = V_RST; m_flush_left = 0; m_ex_rd = 0; m_ex_load = 0;
         end else if (dmem_busy) begin
            exp = V_FRZ;
         end else if (m_flush_left > 0 || ex_branch_taken) begin
            exp = V_FLUSH;
            m_flush_left = (m_flush_left > 0) ? m_flush_left - 1 : BRC - 1;
            m_ex_rd = 0; m_ex_load = 0;
         end else if (id_valid && m_ex_load && m_ex_rd != 0 &&
                      reads_reg(id_opcode, id_rs1, id_rs2, m_ex_rd)) begin
            exp = V_STALL; m_ex_rd = 0; m_ex_load = 0;
         end else begin
            exp = V_RUN; m_ex_rd = id_rd; m_ex_load = id_valid && id_opcode == LD;
         end
         check("cycle_model", outs(), exp);
      end
   end

   // One cycle of directed stimulus with a hand-computed expectation
   task automatic cyc(input string name, input logic r, input logic busy, input logic b,
                      input logic v, input logic [6:0] op, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [4:0] d, input logic [5:0] exp);
      @(posedge clk);
      #1;
      rst = r; dmem_busy = busy; ex_branch_taken = b; id_valid = v;
      id_opcode = op; id_rs1 = s1; id_rs2 = s2; id_rd = d;
      #2;
      check(name, outs(), exp);
      $display("cyc %-14s rst=%b busy=%b br=%b v=%b op=%b rs1=%0d rs2=%0d rd=%0d -> %b",
               name, r, busy, b, v, op, s1, s2, d, outs());
   endtask

   initial begin
      rst = 1; dmem_busy = 0; ex_branch_taken = 0; id_valid = 0;
      id_opcode = NOP; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      cyc("reset0",      1,0,0, 0,NOP,0,0,0, V_RST);
      cyc("reset1",      1,0,0, 0,NOP,0,0,0, V_RST);
      cyc("run_idle",    0,0,0, 0,NOP,0,0,0, V_RUN);
      // load-use on rs1
      cyc("lw_x5",       0,0,0, 1,LD,1,0,5, V_RUN);
      cyc("add_rs1_x5",  0,0,0, 1,RR,5,0,7, V_STALL);
      cyc("add_retry",   0,0,0, 1,RR,5,0,7, V_RUN);
      cyc("nop",         0,0,0, 0,NOP,0,0,0, V_RUN);
      // rd=x0 never stalls
      cyc("lw_x0",       0,0,0, 1,LD,1,0,0, V_RUN);
      cyc("add_rs1_x0",  0,0,0, 1,RR,0,0,8, V_RUN);
      // independent addi; rs2 field matches but IMM ignores rs2
      cyc("lw_x5_b",     0,0,0, 1,LD,1,0,5, V_RUN);
      cyc("addi_rs1_x6", 0,0,0, 1,IM,6,5,9, V_RUN);
      // store data dependency on rs2
      cyc("lw_x5_c",     0,0,0, 1,LD,1,0,5, V_RUN);
      cyc("sw_rs2_x5",   0,0,0, 1,ST,1,5,0, V_STALL);
      cyc("sw_retry",    0,0,0, 1,ST,1,5,0, V_RUN);
      // R-type rs2 dependency
      cyc("lw_x6",       0,0,0, 1,LD,1,0,6, V_RUN);
      cyc("add_rs2_x6",  0,0,0, 1,RR,2,6,10, V_STALL);
      cyc("add_rs2_rt",  0,0,0, 1,RR,2,6,10, V_RUN);
      // invalid ID or invalid load never stalls
      cyc("lw_x5_d",     0,0,0, 1,LD,1,0,5, V_RUN);
      cyc("inv_rs1_x5",  0,0,0, 0,RR,5,0,7, V_RUN);
      cyc("inv_lw_x5",   0,0,0, 0,LD,1,0,5, V_RUN);
      cyc("add_after_iv",0,0,0, 1,RR,5,0,7, V_RUN);
      // two-cycle flush, second branch ignored
      cyc("br_flush1",   0,0,1, 0,NOP,0,0,0, V_FLUSH);
      cyc("br_flush2",   0,0,1, 0,NOP,0,0,0, V_FLUSH);
      cyc("after_flush", 0,0,0, 0,NOP,0,0,0, V_RUN);
      // freeze over a taken branch
      cyc("frz_br1",     0,1,1, 0,NOP,0,0,0, V_FRZ);
      cyc("frz_br2",     0,1,1, 0,NOP,0,0,0, V_FRZ);
      cyc("frz_br3",     0,1,1, 0,NOP,0,0,0, V_FRZ);
      cyc("unfrz_flush1",0,0,1, 0,NOP,0,0,0, V_FLUSH);
      cyc("unfrz_flush2",0,0,0, 0,NOP,0,0,0, V_FLUSH);
      cyc("unfrz_run",   0,0,0, 0,NOP,0,0,0, V_RUN);
      // freeze while a load-use hazard is pending
      cyc("lw_x5_e",     0,0,0, 1,LD,1,0,5, V_RUN);
      cyc("frz_hz1",     0,1,0, 1,RR,5,0,7, V_FRZ);
      cyc("frz_hz2",     0,1,0, 1,RR,5,0,7, V_FRZ);
      cyc("hz_stall",    0,0,0, 1,RR,5,0,7, V_STALL);
      cyc("hz_resume",   0,0,0, 1,RR,5,0,7, V_RUN);
      // branch beats load-use; flush also clears the tracked load
      cyc("lw_x5_f",     0,0,0, 1,LD,1,0,5, V_RUN);
      cyc("br_over_hz",  0,0,1, 1,RR,5,0,7, V_FLUSH);
      cyc("flush2_lw",   0,0,0, 1,LD,1,0,5, V_FLUSH);
      cyc("no_stale_hz", 0,0,0, 1,RR,5,0,7, V_RUN);
      // reset during the second flush cycle
      cyc("br_pre_rst",  0,0,1, 0,NOP,0,0,0, V_FLUSH);
      cyc("rst_in_flush",1,0,0, 0,NOP,0,0,0, V_RST);
      cyc("post_rst1",   0,0,0, 0,NOP,0,0,0, V_RUN);
      cyc("post_rst2",   0,0,0, 0,NOP,0,0,0, V_RUN);
      // freeze pauses an in-progress flush
      cyc("br_pause1",   0,0,1, 0,NOP,0,0,0, V_FLUSH);
      cyc("pause_frz",   0,1,0, 0,NOP,0,0,0, V_FRZ);
      cyc("pause_flush2",0,0,0, 0,NOP,0,0,0, V_FLUSH);
      cyc("pause_run",   0,0,0, 0,NOP,0,0,0, V_RUN);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
